// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux
// Purpose  : N-channel valid/ready arbiter feeding a one-deep registered output
//            stage. Round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
//            Define ARB_MUX_STATS_EN to add the saturating grant_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int c_SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [c_SW-1:0]    out_sel
`ifdef ARB_MUX_STATS_EN
  ,
  output logic [15:0]        grant_cnt
`endif
);

  localparam logic [c_SW:0]   c_N_EXT = (c_SW + 1)'(N);
  localparam logic [c_SW-1:0] c_LAST  = c_SW'(N - 1);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [c_SW-1:0]  r_out_sel;
  logic [c_SW-1:0]  r_ptr;

  logic             w_load;
  logic             w_found;
  logic             w_accept;
  logic [c_SW-1:0]  w_start;
  logic [N-1:0]     w_rot;
  logic [c_SW-1:0]  w_off;
  logic [c_SW:0]    w_sum;
  logic [c_SW-1:0]  w_grant;
  logic [c_SW-1:0]  w_next_ptr;
  logic [N-1:0]     w_in_ready;
  logic [WIDTH-1:0] w_sel_data;

  assign w_load   = !r_out_valid || out_ready;
  assign w_start  = (MODE == 1) ? '0 : r_ptr;
  assign w_accept = w_load && w_found;

  // Rotate the request vector so the search always starts at bit 0.
  assign w_rot = N'({in_valid, in_valid} >> w_start);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_off   = c_SW'(j);
      end
    end
  end

  assign w_sum   = {1'b0, w_start} + {1'b0, w_off};
  assign w_grant = (w_sum >= c_N_EXT) ? c_SW'(w_sum - c_N_EXT) : w_sum[c_SW-1:0];

  assign w_next_ptr = (w_grant == c_LAST) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_in_ready = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == c_SW'(i)) begin
        w_in_ready[i] = w_accept;
        w_sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = w_in_ready;

  // Pointer is maintained in both modes; fixed priority simply ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant;
        r_out_valid <= 1'b1;
        r_ptr       <= w_next_ptr;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

`ifdef ARB_MUX_STATS_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_accept && (r_grant_cnt != 16'hFFFF)) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`else
  // No transfer statistics in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux
// Purpose  : Directed self-checking bench for arb_mux; one round-robin and one
//            fixed-priority instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready_rr, in_ready_fp;
  logic [15:0] out_data_rr, out_data_fp;
  logic        out_valid_rr, out_valid_fp;
  logic [1:0]  out_sel_rr, out_sel_fp;
`ifdef ARB_MUX_STATS_EN
  logic [15:0] grant_cnt_rr, grant_cnt_fp;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_rr_sel[3] = '{1, 3, 1};

  arb_mux #(.WIDTH(16), .N(4), .MODE(0)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_rr),
    .out_data  (out_data_rr),
    .out_valid (out_valid_rr),
    .out_ready (out_ready),
    .out_sel   (out_sel_rr)
`ifdef ARB_MUX_STATS_EN
    ,
    .grant_cnt (grant_cnt_rr)
`endif
  );

  arb_mux #(.WIDTH(16), .N(4), .MODE(1)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_fp),
    .out_data  (out_data_fp),
    .out_valid (out_valid_fp),
    .out_ready (out_ready),
    .out_sel   (out_sel_fp)
`ifdef ARB_MUX_STATS_EN
    ,
    .grant_cnt (grant_cnt_fp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std_data();
    for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'hA000 + 16'(i);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid_rr", out_valid_rr, 0);
    check("rst_data_rr",  out_data_rr,  0);
    check("rst_sel_rr",   out_sel_rr,   0);
    check("rst_valid_fp", out_valid_fp, 0);
    check("rst_ready_rr", in_ready_rr,  0);
    rst = 1'b0;

    // Round-robin walk with every channel requesting
    set_std_data();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check("rr_first_ready", in_ready_rr, 4'b0001);
    check("fp_first_ready", in_ready_fp, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_walk_sel",   out_sel_rr,   k % 4);
      check("rr_walk_data",  out_data_rr,  16'hA000 + 16'(k % 4));
      check("rr_walk_valid", out_valid_rr, 1);
      check("rr_walk_ready", in_ready_rr,  32'(1 << ((k + 1) % 4)));
      check("fp_walk_sel",   out_sel_fp,   0);
    end

    // Sparse request pattern 1010
    in_valid = 4'b1010;
    #1;
    check("fp_1010_ready0", in_ready_fp, 4'b0010);
    check("rr_1010_ready0", in_ready_rr, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_1010_sel",   out_sel_fp,  1);
      check("fp_1010_ready", in_ready_fp, 4'b0010);
      check("rr_1010_sel",   out_sel_rr,  exp_rr_sel[k]);
    end

    // Back-pressure holds the output word and the pointer
    in_data[2*16 +: 16] = 16'h1234;
    in_valid = 4'b0100;
    tick();
    check("bp_load_data_rr", out_data_rr, 16'h1234);
    check("bp_load_sel_rr",  out_sel_rr,  2);
    check("bp_load_data_fp", out_data_fp, 16'h1234);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'hF - 4'(k);
      in_data  = {4{16'(k)}};
      #1;
      check("bp_ready_rr", in_ready_rr, 0);
      check("bp_ready_fp", in_ready_fp, 0);
      tick();
      check("bp_data_rr",  out_data_rr,  16'h1234);
      check("bp_sel_rr",   out_sel_rr,   2);
      check("bp_valid_rr", out_valid_rr, 1);
    end
    set_std_data();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check("bp_ptr_held_rr", in_ready_rr, 4'b1000);
    check("bp_after_fp",    in_ready_fp, 4'b0001);
    tick();
    check("bp_resume_sel_rr",  out_sel_rr,  3);
    check("bp_resume_data_rr", out_data_rr, 16'hA003);

    // Drain: valid drops, data holds
    in_valid = 4'b0000;
    #1;
    check("drain_ready_rr", in_ready_rr, 0);
    tick();
    check("drain_valid_rr", out_valid_rr, 0);
    check("drain_data_rr",  out_data_rr,  16'hA003);
    check("drain_sel_rr",   out_sel_rr,   3);
    check("drain_valid_fp", out_valid_fp, 0);
    check("drain_data_fp",  out_data_fp,  16'hA000);

    // Empty stage accepts even with out_ready low
    out_ready = 1'b0;
    in_valid  = 4'hF;
    #1;
    check("empty_load_ready_rr", in_ready_rr, 4'b0001);
    tick();
    check("empty_load_valid_rr", out_valid_rr, 1);
    check("empty_load_sel_rr",   out_sel_rr,   0);
    check("full_stall_ready_rr", in_ready_rr,  0);

    // Asynchronous reset between edges while holding a word
    out_ready = 1'b1;
    tick();
    check("pre_rst_sel_rr",  out_sel_rr,  1);
    check("pre_rst_data_rr", out_data_rr, 16'hA001);
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid_rr", out_valid_rr, 0);
    check("async_rst_data_rr",  out_data_rr,  0);
    check("async_rst_sel_rr",   out_sel_rr,   0);
    check("async_rst_valid_fp", out_valid_fp, 0);
`ifdef ARB_MUX_STATS_EN
    check("async_rst_cnt", grant_cnt_rr, 0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    #1;
    check("post_rst_ready_rr", in_ready_rr, 4'b0001);
    tick();
    check("post_rst_sel_rr",  out_sel_rr,  0);
    check("post_rst_data_rr", out_data_rr, 16'hA000);
    check("post_rst_sel_fp",  out_sel_fp,  0);

`ifdef ARB_MUX_STATS_EN
    check("cnt_one", grant_cnt_rr, 1);
    repeat (70000) @(posedge clk);
    #1;
    check("cnt_sat_rr", grant_cnt_rr, 16'hFFFF);
    check("cnt_sat_fp", grant_cnt_fp, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
